// File: rtl/ifid_hazard_ctrl_if.sv
// ifid_hazard_ctrl_if: signal bundle between the pipeline datapath and the
// IF/ID hazard controller.
//   master : pipeline side; drives the ID/EX hazard inputs and the imem ready flag,
//            receives the PC / IF-ID enables, bubble controls and statistics.
//   slave  : the hazard controller itself.
//   CNT_W  : width of the stall / flush statistics counters.
interface ifid_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    // Instruction in ID
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic             rs1_used_ID;
    logic             rs2_used_ID;
    logic             valid_ID;
    // Instruction in EX
    logic [4:0]       rd_EX;
    logic             MemRead_EX;
    logic             valid_EX;
    logic             branch_taken_EX;
    // Instruction memory
    logic             imem_ready;
    // Pipeline control
    logic             en_PC;
    logic             en_IFID;
    logic             NOP_IFID;
    logic             NOP_IDEX;
    // Status / statistics
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             fetch_timeout;
    logic [1:0]       state;

    modport master (
        output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, valid_ID,
        output rd_EX, MemRead_EX, valid_EX, branch_taken_EX, imem_ready,
        input  en_PC, en_IFID, NOP_IFID, NOP_IDEX,
        input  stall_cnt, flush_cnt, fetch_timeout, state
    );

    modport slave (
        input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, valid_ID,
        input  rd_EX, MemRead_EX, valid_EX, branch_taken_EX, imem_ready,
        output en_PC, en_IFID, NOP_IFID, NOP_IDEX,
        output stall_cnt, flush_cnt, fetch_timeout, state
    );
endinterface

// File: rtl/ifid_hazard_ctrl.sv
// ifid_hazard_ctrl: IF/ID hazard controller. Resolves taken branches (flush),
// load-use hazards (one-cycle stall) and instruction-memory wait (fetch hold),
// in that priority, and keeps saturating statistics plus a sticky fetch timeout.
// Ports:
//   clk_IFID  : clock, rising edge
//   rst_IFID  : asynchronous, active-high reset
//   bus       : ifid_hazard_ctrl_if.slave (ID/EX hazard inputs, imem_ready,
//               en_PC/en_IFID, NOP_IFID/NOP_IDEX, stall_cnt/flush_cnt,
//               fetch_timeout, state)
module ifid_hazard_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WAIT_MAX = 8
) (
    input logic                clk_IFID,
    input logic                rst_IFID,
    ifid_hazard_ctrl_if.slave  bus
);

    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StFlush     = 2'd2,
        StFetchWait = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic do_flush;
    logic do_stall;
    logic en_pc, en_ifid, nop_ifid, nop_idex;

    always_comb begin
        load_use = bus.valid_ID & bus.valid_EX & bus.MemRead_EX & (bus.rd_EX != 5'd0) &
                   ((bus.rs1_used_ID & (bus.rs1_ID == bus.rd_EX)) |
                    (bus.rs2_used_ID & (bus.rs2_ID == bus.rd_EX)));

        // Normal outputs by default
        en_pc    = 1'b1;
        en_ifid  = 1'b1;
        nop_ifid = 1'b0;
        nop_idex = 1'b0;
        state_d  = StRun;
        do_flush = 1'b0;
        do_stall = 1'b0;

        if (bus.branch_taken_EX) begin
            nop_ifid = 1'b1;
            nop_idex = 1'b1;
            state_d  = StFlush;
            do_flush = 1'b1;
        end else if (load_use && (state_q != StLoadStall)) begin
            // The stalled instruction is re-evaluated next cycle against a
            // bubble in EX, so detection is masked while in LOAD_STALL.
            en_pc    = 1'b0;
            en_ifid  = 1'b0;
            nop_idex = 1'b1;
            state_d  = StLoadStall;
            do_stall = 1'b1;
        end else if (!bus.imem_ready) begin
            // Hold the PC and feed a bubble into IF/ID until memory responds.
            en_pc    = 1'b0;
            nop_ifid = 1'b1;
            state_d  = StFetchWait;
        end

        if (rst_IFID) begin
            en_pc    = 1'b0;
            en_ifid  = 1'b0;
            nop_ifid = 1'b1;
            nop_idex = 1'b1;
        end
    end

    // Wait counter tracks consecutive fetch-wait cycles, including the cycle
    // that enters FETCH_WAIT, and clears on any other transition.
    always_comb begin
        wait_cnt_d = '0;
        if (state_d == StFetchWait) begin
            if (wait_cnt_q == WAIT_W'(WAIT_MAX)) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end
        timeout_d = timeout_q | (wait_cnt_d == WAIT_W'(WAIT_MAX));

        stall_cnt_d = stall_cnt_q;
        if (do_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (do_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_IFID or posedge rst_IFID) begin
        if (rst_IFID) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.en_PC         = en_pc;
    assign bus.en_IFID       = en_ifid;
    assign bus.NOP_IFID      = nop_ifid;
    assign bus.NOP_IDEX      = nop_idex;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;
    assign bus.fetch_timeout = timeout_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// tb_ifid_hazard_ctrl: self-checking bench for ifid_hazard_ctrl (CNT_W=4,
// WAIT_MAX=8). Directed scenarios plus a randomized run against a
// behavioural model of the hazard rules.
module tb_ifid_hazard_ctrl;

    localparam int CNT_MAX  = 15;
    localparam int WAIT_LIM = 8;

    logic clk_IFID;
    logic rst_IFID;

    ifid_hazard_ctrl_if #(.CNT_W(4)) bus ();

    ifid_hazard_ctrl #(
        .CNT_W    (4),
        .WAIT_MAX (8)
    ) dut (
        .clk_IFID (clk_IFID),
        .rst_IFID (rst_IFID),
        .bus      (bus.slave)
    );

    initial clk_IFID = 1'b0;
    always #5 clk_IFID = ~clk_IFID;

    int checks;
    int passes;

    // Model: architectural state and expected response for the current inputs
    int       m_state;
    int       m_stall_cnt;
    int       m_flush_cnt;
    int       m_wait;
    bit       m_timeout;
    logic [3:0] e_ctl;  // {en_PC, en_IFID, NOP_IFID, NOP_IDEX}
    int       e_next;
    bit       e_stall;
    bit       e_flush;

    wire [3:0] ctl = {bus.en_PC, bus.en_IFID, bus.NOP_IFID, bus.NOP_IDEX};

    task automatic model_reset();
        m_state = 0; m_stall_cnt = 0; m_flush_cnt = 0; m_wait = 0; m_timeout = 0;
    endtask

    task automatic model_eval();
        bit lu;
        lu = bus.valid_ID && bus.valid_EX && bus.MemRead_EX && (bus.rd_EX != 0) &&
             ((bus.rs1_used_ID && bus.rs1_ID == bus.rd_EX) ||
              (bus.rs2_used_ID && bus.rs2_ID == bus.rd_EX)) && (m_state != 1);
        e_stall = 0;
        e_flush = 0;
        if (bus.branch_taken_EX) begin
            e_ctl = 4'b1111; e_next = 2; e_flush = 1;
        end else if (lu) begin
            e_ctl = 4'b0001; e_next = 1; e_stall = 1;
        end else if (!bus.imem_ready) begin
            e_ctl = 4'b0110; e_next = 3;
        end else begin
            e_ctl = 4'b1100; e_next = 0;
        end
    endtask

    task automatic model_commit();
        m_state = e_next;
        if (e_stall) m_stall_cnt = (m_stall_cnt < CNT_MAX) ? m_stall_cnt + 1 : CNT_MAX;
        if (e_flush) m_flush_cnt = (m_flush_cnt < CNT_MAX) ? m_flush_cnt + 1 : CNT_MAX;
        m_wait = (e_next == 3) ? ((m_wait < WAIT_LIM) ? m_wait + 1 : WAIT_LIM) : 0;
        if (m_wait == WAIT_LIM) m_timeout = 1;
    endtask

    // Advance one clock; returns at posedge+1
    task automatic tick();
        model_eval();
        @(posedge clk_IFID);
        model_commit();
        #1;
    endtask

    task automatic quiet();
        bus.rs1_ID = 5'd0; bus.rs2_ID = 5'd0;
        bus.rs1_used_ID = 1'b0; bus.rs2_used_ID = 1'b0; bus.valid_ID = 1'b0;
        bus.rd_EX = 5'd0; bus.MemRead_EX = 1'b0; bus.valid_EX = 1'b0;
        bus.branch_taken_EX = 1'b0; bus.imem_ready = 1'b1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        bus.rd_EX = rd; bus.MemRead_EX = 1'b1; bus.valid_EX = 1'b1;
        bus.rs1_ID = 5'd5; bus.rs1_used_ID = 1'b1; bus.valid_ID = 1'b1;
        bus.rs2_ID = 5'd0; bus.rs2_used_ID = 1'b0;
    endtask

    // Mid-cycle reset pulse (called at posedge+1)
    task automatic do_reset();
        quiet();
        rst_IFID = 1'b1;
        #2;
        rst_IFID = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        quiet();
        rst_IFID = 1'b1;
        repeat (2) @(posedge clk_IFID);
        #1;
        checks++; if (ctl !== 4'b0011) $display("FAIL reset_ctl: got %b want 0011", ctl); else passes++;
        checks++; if (bus.state !== 2'd0) $display("FAIL reset_state: got %0d want 0", bus.state); else passes++;
        checks++; if ({bus.stall_cnt, bus.flush_cnt, bus.fetch_timeout} !== 9'd0)
            $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0",
                     bus.stall_cnt, bus.flush_cnt, bus.fetch_timeout);
        else passes++;
        rst_IFID = 1'b0;
        model_reset();
        #1;
        checks++; if (ctl !== 4'b1100) $display("FAIL reset_release_ctl: got %b want 1100", ctl); else passes++;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5'd5);
        #1;
        checks++; if (ctl !== 4'b0001) $display("FAIL lu_stall_ctl: got %b want 0001", ctl); else passes++;
        tick();
        checks++; if (bus.state !== 2'd1) $display("FAIL lu_state: got %0d want 1", bus.state); else passes++;
        checks++; if (bus.stall_cnt !== 4'd1) $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt); else passes++;
        // Hazard still presented, but masked during LOAD_STALL
        checks++; if (ctl !== 4'b1100) $display("FAIL lu_after_ctl: got %b want 1100", ctl); else passes++;
        quiet();
        tick();
        checks++; if (bus.state !== 2'd0 || bus.stall_cnt !== 4'd1)
            $display("FAIL lu_return: got state %0d cnt %0d want 0/1", bus.state, bus.stall_cnt);
        else passes++;
    endtask

    task automatic test_rd_zero();
        do_reset();
        set_load_use(5'd0);
        bus.rs1_ID = 5'd0;
        #1;
        checks++; if (ctl !== 4'b1100) $display("FAIL rd0_ctl: got %b want 1100", ctl); else passes++;
        tick();
        checks++; if (bus.stall_cnt !== 4'd0 || bus.state !== 2'd0)
            $display("FAIL rd0_nostall: got cnt %0d state %0d want 0/0", bus.stall_cnt, bus.state);
        else passes++;
        quiet();
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_load_use(5'd5);
        bus.branch_taken_EX = 1'b1;
        bus.imem_ready = 1'b0;
        #1;
        checks++; if (ctl !== 4'b1111) $display("FAIL br_ctl: got %b want 1111", ctl); else passes++;
        tick();
        checks++; if (bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd0 || bus.state !== 2'd2)
            $display("FAIL br_state: got flush %0d stall %0d state %0d want 1/0/2",
                     bus.flush_cnt, bus.stall_cnt, bus.state);
        else passes++;
        quiet();
        tick();
        checks++; if (bus.state !== 2'd0) $display("FAIL br_exit: got %0d want 0", bus.state); else passes++;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            bus.imem_ready = 1'b0;
            #1;
            checks++; if (ctl !== 4'b0110) $display("FAIL to_ctl_%0d: got %b want 0110", k, ctl); else passes++;
            tick();
            checks++; if (bus.fetch_timeout !== (k >= 8) || bus.state !== 2'd3)
                $display("FAIL to_flag_%0d: got to %0d state %0d want %0d/3",
                         k, bus.fetch_timeout, bus.state, (k >= 8));
            else passes++;
        end
        bus.imem_ready = 1'b1;
        #1;
        checks++; if (ctl !== 4'b1100) $display("FAIL to_resume_ctl: got %b want 1100", ctl); else passes++;
        tick();
        checks++; if (bus.fetch_timeout !== 1'b1 || bus.state !== 2'd0)
            $display("FAIL to_sticky: got to %0d state %0d want 1/0", bus.fetch_timeout, bus.state);
        else passes++;
    endtask

    task automatic test_saturation();
        do_reset();
        bus.branch_taken_EX = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++; if (bus.flush_cnt !== 4'((k > 15) ? 15 : k))
                $display("FAIL sat_%0d: got %0d want %0d", k, bus.flush_cnt, (k > 15) ? 15 : k);
            else passes++;
        end
        checks++; if (bus.flush_cnt !== 4'd15 || bus.state !== 2'd2)
            $display("FAIL sat_final: got %0d state %0d want 15/2", bus.flush_cnt, bus.state);
        else passes++;
        quiet();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus.branch_taken_EX = 1'b1;
        tick();
        quiet();
        set_load_use(5'd5);
        tick();
        quiet();
        bus.imem_ready = 1'b0;
        repeat (9) tick();
        checks++; if (bus.state !== 2'd3 || bus.fetch_timeout !== 1'b1 ||
                      bus.stall_cnt !== 4'd1 || bus.flush_cnt !== 4'd1)
            $display("FAIL rmw_pre: got state %0d to %0d stall %0d flush %0d want 3/1/1/1",
                     bus.state, bus.fetch_timeout, bus.stall_cnt, bus.flush_cnt);
        else passes++;
        #2;
        rst_IFID = 1'b1;
        #1;
        // No clock edge since reset rose
        checks++; if (bus.state !== 2'd0 || bus.fetch_timeout !== 1'b0 ||
                      bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0)
            $display("FAIL rmw_async: got state %0d to %0d stall %0d flush %0d want 0/0/0/0",
                     bus.state, bus.fetch_timeout, bus.stall_cnt, bus.flush_cnt);
        else passes++;
        checks++; if (ctl !== 4'b0011) $display("FAIL rmw_ctl: got %b want 0011", ctl); else passes++;
        quiet();
        rst_IFID = 1'b0;
        model_reset();
        @(posedge clk_IFID);
        #1;
        checks++; if (ctl !== 4'b1100 || bus.state !== 2'd0)
            $display("FAIL rmw_after: got ctl %b state %0d want 1100/0", ctl, bus.state);
        else passes++;
        model_eval();
        @(posedge clk_IFID);
        model_commit();
        #1;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.rs1_ID          = 5'($urandom_range(0, 3));
            bus.rs2_ID          = 5'($urandom_range(0, 3));
            bus.rd_EX           = 5'($urandom_range(0, 3));
            bus.rs1_used_ID     = 1'($urandom_range(0, 1));
            bus.rs2_used_ID     = 1'($urandom_range(0, 1));
            bus.valid_ID        = ($urandom_range(0, 7) != 0);
            bus.valid_EX        = ($urandom_range(0, 7) != 0);
            bus.MemRead_EX      = 1'($urandom_range(0, 1));
            bus.branch_taken_EX = ($urandom_range(0, 7) == 0);
            bus.imem_ready      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 5) begin
                // Burst of memory wait to reach the timeout occasionally
                bus.branch_taken_EX = 1'b0;
                bus.valid_EX = 1'b0;
                bus.imem_ready = 1'b0;
            end
            #1;
            model_eval();
            checks++; if (ctl !== e_ctl) begin
                $display("FAIL rand_ctl_%0d: got %b want %b", n, ctl, e_ctl); errs++;
            end else passes++;
            checks++; if (bus.state !== 2'(m_state) || bus.stall_cnt !== 4'(m_stall_cnt) ||
                          bus.flush_cnt !== 4'(m_flush_cnt) || bus.fetch_timeout !== m_timeout) begin
                $display("FAIL rand_state_%0d: got st %0d sc %0d fc %0d to %0d want %0d/%0d/%0d/%0d",
                         n, bus.state, bus.stall_cnt, bus.flush_cnt, bus.fetch_timeout,
                         m_state, m_stall_cnt, m_flush_cnt, m_timeout);
                errs++;
            end else passes++;
            if (errs > 10) break;
            if ($urandom_range(0, 99) == 0) do_reset();
            else tick();
        end
        quiet();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        model_reset();
        test_reset();
        test_load_use();
        test_rd_zero();
        test_branch_priority();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
